// File: rtl/flash_rom_loader_pkg.sv
// Shared constants and state encoding for the flash-to-boot-ROM copier.
// The READ command word is opcode followed by the 24-bit start address.
package flash_rom_loader_pkg;

  localparam logic [7:0] READ_OPCODE = 8'h03;
  localparam int         CMD_BITS    = 32;
  localparam int         CMD_BYTES   = CMD_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DATA   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic logic [CMD_BITS-1:0] read_cmd(input logic [23:0] addr);
    return {READ_OPCODE, addr};
  endfunction

endpackage

// File: rtl/flash_rom_loader_spi_bit_engine.sv
// SPI mode-0 bit engine: half-period divider, flash clock, MSB-first shift-out
// of the command word and shift-in of read data with per-byte strobes.
module spi_bit_engine #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_run,
  input  logic [31:0] i_tx_word,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_byte_ready,
  output logic        o_byte_end,
  output logic [7:0]  o_rx_byte
);

  localparam int                DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic [31:0]      r_tx;
  logic [6:0]       r_rx;
  logic [2:0]       r_bitcnt;

  logic             w_div_last;
  logic             w_sample;
  logic             w_bit_end;
  logic [7:0]       w_rx;

  assign w_div_last = (r_div == DIV_LAST);
  // Sample on the cycle whose closing edge raises flash_clk; a bit ends when the high phase does.
  assign w_sample   = i_run && !r_sclk && w_div_last;
  assign w_bit_end  = i_run &&  r_sclk && w_div_last;
  assign w_rx       = {r_rx, i_miso};

  assign o_sclk       = r_sclk;
  assign o_mosi       = r_tx[31];
  assign o_rx_byte    = w_rx;
  assign o_byte_ready = w_sample  && (r_bitcnt == 3'd7);
  assign o_byte_end   = w_bit_end && (r_bitcnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_sclk   <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_bitcnt <= '0;
    end else if (i_load) begin
      r_div    <= '0;
      r_sclk   <= 1'b0;
      r_tx     <= i_tx_word;
      r_rx     <= '0;
      r_bitcnt <= '0;
    end else if (!i_run) begin
      r_div    <= '0;
      r_sclk   <= 1'b0;
    end else begin
      r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
      if (w_div_last) r_sclk <= ~r_sclk;
      if (w_sample)   r_rx   <= w_rx[6:0];
      if (w_bit_end) begin
        // Replicate the LSB so mosi keeps the last address bit through the data phase.
        r_tx     <= {r_tx[30:0], r_tx[0]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/flash_rom_loader.sv
// Boot-time copier: issues a SPI flash READ and streams LENGTH bytes into the
// boot ROM write port, holding busy until the image is complete.
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          LENGTH     = 16384,
  parameter int          ADDR_W     = 14,
  parameter int          CLKDIV     = 2,
  parameter int          AUTOSTART  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              flash_cs_n,
  output logic              flash_clk,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output state_e            o_dbg_state
);

  localparam int                    CMD_CNT_W    = $clog2(CMD_BYTES);
  localparam logic [CMD_CNT_W-1:0]  CMD_CNT_LAST = CMD_CNT_W'(CMD_BYTES - 1);
  localparam logic [ADDR_W-1:0]     LEN_LAST     = ADDR_W'(LENGTH - 1);
  localparam int                    GAP_W        = $clog2(2 * CLKDIV);
  localparam logic [GAP_W-1:0]      GAP_LAST     = GAP_W'(2 * CLKDIV - 1);

  state_e                r_state;
  state_e                w_next;
  logic [CMD_CNT_W-1:0]  r_cmd_cnt;
  logic [ADDR_W-1:0]     r_byte;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_pend;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_a;
  logic [7:0]            r_dout;

  logic                  w_busy;
  logic                  w_enter_cmd;
  logic                  w_byte_ready;
  logic                  w_byte_end;
  logic [7:0]            w_rx_byte;

  spi_bit_engine #(
    .CLKDIV (CLKDIV)
  ) u_engine (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_enter_cmd),
    .i_run        (w_busy),
    .i_tx_word    (read_cmd(FLASH_BASE)),
    .i_miso       (flash_miso),
    .o_sclk       (flash_clk),
    .o_mosi       (flash_mosi),
    .o_byte_ready (w_byte_ready),
    .o_byte_end   (w_byte_end),
    .o_rx_byte    (w_rx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b0;
    w_enter_cmd = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((AUTOSTART != 0) || start) w_next = ST_CMD;
      end
      ST_CMD: begin
        w_busy = 1'b1;
        if (w_byte_end && (r_cmd_cnt == CMD_CNT_LAST)) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_busy = 1'b1;
        if (w_byte_end && (r_byte == LEN_LAST)) w_next = ST_FINISH;
      end
      ST_FINISH: begin
        // A restart waits until chip select has been high for a full bit time.
        if ((start || r_pend) && (r_gap == GAP_LAST)) w_next = ST_CMD;
      end
      default: w_next = ST_IDLE;
    endcase
    if (!w_busy && (w_next == ST_CMD)) w_enter_cmd = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_cnt <= '0;
      r_byte    <= '0;
      r_gap     <= '0;
      r_pend    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (r_state != ST_FINISH)  r_gap <= '0;
      else if (r_gap != GAP_LAST) r_gap <= r_gap + GAP_W'(1);

      if (w_enter_cmd)                        r_pend <= 1'b0;
      else if ((r_state == ST_FINISH) && start) r_pend <= 1'b1;

      if (w_enter_cmd)                                      r_done <= 1'b0;
      else if ((r_state == ST_DATA) && (w_next == ST_FINISH)) r_done <= 1'b1;

      if (w_enter_cmd) begin
        r_cmd_cnt <= '0;
        r_byte    <= '0;
      end else if (w_byte_end) begin
        if (r_state == ST_CMD) r_cmd_cnt <= r_cmd_cnt + CMD_CNT_W'(1);
        // Holding at the last index keeps a full-size image from wrapping the address.
        else if ((r_state == ST_DATA) && (r_byte != LEN_LAST)) r_byte <= r_byte + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_a    <= '0;
      r_dout <= '0;
    end else if ((r_state == ST_DATA) && w_byte_ready) begin
      r_we   <= 1'b1;
      r_a    <= r_byte;
      r_dout <= w_rx_byte;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign flash_cs_n  = !w_busy;
  assign busy        = w_busy;
  assign done        = r_done;
  assign mem_we      = r_we;
  assign mem_a       = r_a;
  assign mem_dout    = r_dout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Bench for flash_rom_loader: four parameterisations share one flash model and
// one write scoreboard; only the selected instance is held out of reset.
module tb_flash_rom_loader;
  import flash_rom_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic [3:0] rst_n;
  logic [3:0] start;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [3:0] cs_n, sclk, mosi, miso, we, busy, done;
  logic [13:0] mem_a0, mem_a1, mem_a2;
  logic [2:0]  mem_a3;
  logic [7:0]  dout0, dout1, dout2, dout3;
  state_e      dbg0, dbg1, dbg2, dbg3;

  flash_rom_loader #(.FLASH_BASE(24'h010000), .LENGTH(4), .ADDR_W(14), .CLKDIV(2), .AUTOSTART(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .flash_cs_n(cs_n[0]), .flash_clk(sclk[0]),
    .flash_mosi(mosi[0]), .flash_miso(miso[0]), .mem_a(mem_a0), .mem_dout(dout0), .mem_we(we[0]),
    .busy(busy[0]), .done(done[0]), .o_dbg_state(dbg0));
  flash_rom_loader #(.FLASH_BASE(24'h000000), .LENGTH(1), .ADDR_W(14), .CLKDIV(1), .AUTOSTART(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .flash_cs_n(cs_n[1]), .flash_clk(sclk[1]),
    .flash_mosi(mosi[1]), .flash_miso(miso[1]), .mem_a(mem_a1), .mem_dout(dout1), .mem_we(we[1]),
    .busy(busy[1]), .done(done[1]), .o_dbg_state(dbg1));
  flash_rom_loader #(.FLASH_BASE(24'h123456), .LENGTH(4), .ADDR_W(14), .CLKDIV(2), .AUTOSTART(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .flash_cs_n(cs_n[2]), .flash_clk(sclk[2]),
    .flash_mosi(mosi[2]), .flash_miso(miso[2]), .mem_a(mem_a2), .mem_dout(dout2), .mem_we(we[2]),
    .busy(busy[2]), .done(done[2]), .o_dbg_state(dbg2));
  flash_rom_loader #(.FLASH_BASE(24'h0000F8), .LENGTH(8), .ADDR_W(3), .CLKDIV(1), .AUTOSTART(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n[3]), .start(start[3]), .flash_cs_n(cs_n[3]), .flash_clk(sclk[3]),
    .flash_mosi(mosi[3]), .flash_miso(miso[3]), .mem_a(mem_a3), .mem_dout(dout3), .mem_we(we[3]),
    .busy(busy[3]), .done(done[3]), .o_dbg_state(dbg3));

  int sel;
  logic [13:0] cur_a;
  logic [7:0]  cur_dout;
  state_e      cur_state;

  always_comb begin
    cur_a     = mem_a0;
    cur_dout  = dout0;
    cur_state = dbg0;
    case (sel)
      1: begin cur_a = mem_a1;          cur_dout = dout1; cur_state = dbg1; end
      2: begin cur_a = mem_a2;          cur_dout = dout2; cur_state = dbg2; end
      3: begin cur_a = {11'b0, mem_a3}; cur_dout = dout3; cur_state = dbg3; end
      default: ;
    endcase
  end

  // ---------------- flash model + protocol watch ----------------
  // Responds to READ with byte (addr[7:0] ^ 5A); data changes on flash_clk falling edges.
  int          bitn [4];
  logic [31:0] fcmd [4];
  logic [31:0] cmd_seen [4];
  logic [3:0]  prev_sclk, prev_mosi;
  int          viol;
  int          m_idx;
  logic [23:0] m_addr;
  logic [7:0]  m_byte;

  initial begin
    miso = '0; prev_sclk = '0; prev_mosi = '0; viol = 0;
    for (int g = 0; g < 4; g++) begin bitn[g] = 0; fcmd[g] = '0; cmd_seen[g] = '0; end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (cs_n[g]) begin
        bitn[g] = 0;
        miso[g] = 1'b0;
        if (sclk[g]) viol++;
      end else if (sclk[g] && !prev_sclk[g]) begin
        if (bitn[g] < 32) begin
          fcmd[g] = {fcmd[g][30:0], mosi[g]};
          if (bitn[g] == 31) cmd_seen[g] = fcmd[g];
        end
        bitn[g]++;
      end else if (!sclk[g] && prev_sclk[g] && bitn[g] >= 32) begin
        m_idx   = bitn[g] - 32;
        m_addr  = fcmd[g][23:0] + 24'(m_idx / 8);
        m_byte  = m_addr[7:0] ^ 8'h5A;
        miso[g] = m_byte[7 - (m_idx % 8)];
      end
      if (sclk[g] && (mosi[g] != prev_mosi[g])) viol++;
      prev_sclk[g] = sclk[g];
      prev_mosi[g] = mosi[g];
    end
  end

  // ---------------- scoreboard / checking ----------------
  int checks, failures;
  int wr_cnt, busy_cnt;
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] base, input int k);
    logic [23:0] a;
    a = base + 24'(k);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic push_exp(input logic [23:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({14'(k), exp_byte(base, k)});
  endtask

  // Advance one clock; observe the selected instance on the falling edge.
  task automatic step();
    logic [21:0] e;
    @(negedge clk);
    if (busy[sel]) busy_cnt++;
    if (we[sel]) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got write a=%0h d=%0h expected no write", cur_a, cur_dout);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", 32'({cur_a, cur_dout}), 32'(e));
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done[sel] && n < budget) begin step(); n++; end
    check("done_reached", 32'(done[sel]), 32'd1);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dut;
    logic [23:0] base;
    int          len;
    int          div;
  } vec_t;
  vec_t vecs [3];

  initial begin
    int hi_cnt, n;
    checks = 0; failures = 0; wr_cnt = 0; busy_cnt = 0; sel = 0;
    rst_n = '0; start = '0;

    vecs[0] = '{dut: 0, base: 24'h010000, len: 4, div: 2};
    vecs[1] = '{dut: 1, base: 24'h000000, len: 1, div: 1};
    vecs[2] = '{dut: 3, base: 24'h0000F8, len: 8, div: 1};

    repeat (3) step();
    check("rst_cs_n",  32'(cs_n[0]), 32'd1);
    check("rst_sclk",  32'(sclk[0]), 32'd0);
    check("rst_mosi",  32'(mosi[0]), 32'd0);
    check("rst_we",    32'(we[0]),   32'd0);
    check("rst_a_d",   32'({cur_a, cur_dout}), 32'd0);
    check("rst_busy",  32'({busy[0], done[0]}), 32'd0);
    check("rst_state", 32'(cur_state), 32'(ST_IDLE));

    for (int i = 0; i < 3; i++) begin
      sel = vecs[i].dut; wr_cnt = 0; busy_cnt = 0;
      push_exp(vecs[i].base, vecs[i].len);
      rst_n[sel] = 1'b1;
      wait_done(5000);
      repeat (10) step();
      check("end_busy",   32'(busy[sel]), 32'd0);
      check("end_done",   32'(done[sel]), 32'd1);
      check("end_cs_n",   32'(cs_n[sel]), 32'd1);
      check("end_state",  32'(cur_state), 32'(ST_FINISH));
      check("wr_count",   32'(wr_cnt), 32'(vecs[i].len));
      check("sb_left",    32'(exp_q.size()), 32'd0);
      check("mosi_cmd",   cmd_seen[sel], {8'h03, vecs[i].base});
      check_range("busy_cycles", busy_cnt,
                  (32 + 8 * vecs[i].len) * 2 * vecs[i].div - 1,
                  (32 + 8 * vecs[i].len) * 2 * vecs[i].div + 1);
      check("last_addr",  32'(cur_a), 32'(vecs[i].len - 1));
      exp_q.delete();
    end

    // Reset during byte 2 of a 4-byte load.
    sel = 0;
    rst_n[0] = 1'b0; #1;
    check("rst_clears_done", 32'(done[0]), 32'd0);
    step(); step();
    wr_cnt = 0;
    push_exp(24'h010000, 2);
    rst_n[0] = 1'b1;
    n = 0;
    while (wr_cnt < 2 && n < 2000) begin step(); n++; end
    check("pre_abort_writes", 32'(wr_cnt), 32'd2);
    repeat (10) step();
    rst_n[0] = 1'b0; #1;
    check("abort_cs_n", 32'(cs_n[0]), 32'd1);
    check("abort_bdw",  32'({busy[0], done[0], we[0], sclk[0]}), 32'd0);
    repeat (20) step();
    check("abort_no_write", 32'(wr_cnt), 32'd2);
    wr_cnt = 0; busy_cnt = 0;
    push_exp(24'h010000, 4);
    rst_n[0] = 1'b1;
    wait_done(5000);
    step();
    check("reload_wr", 32'(wr_cnt), 32'd4);
    check("reload_sb", 32'(exp_q.size()), 32'd0);
    check_range("reload_busy", busy_cnt, 255, 257);

    // Manual start: reset wins over start, then start, start-while-busy, restart.
    sel = 2; wr_cnt = 0; busy_cnt = 0;
    pulse_start(2);
    rst_n[2] = 1'b1;
    repeat (30) step();
    check("nostart_idle", 32'({busy[2], cs_n[2], done[2]}), 32'b010);
    check("nostart_wr",   32'(wr_cnt), 32'd0);
    push_exp(24'h123456, 4);
    pulse_start(2);
    check("start_busy", 32'({busy[2], cs_n[2]}), 32'b10);
    repeat (100) step();
    pulse_start(2);
    wait_done(5000);
    check("ignored_start_wr", 32'(wr_cnt), 32'd4);
    check_range("manual_busy", busy_cnt, 255, 257);
    check("manual_sb", 32'(exp_q.size()), 32'd0);
    check("manual_cmd", cmd_seen[2], 32'h03123456);

    wr_cnt = 0; busy_cnt = 0;
    hi_cnt = cs_n[2] ? 1 : 0;
    push_exp(24'h123456, 4);
    pulse_start(2);
    n = 0;
    while (!busy[2] && n < 20) begin
      if (cs_n[2]) hi_cnt++;
      step(); n++;
    end
    check("early_start_kept", 32'(busy[2]), 32'd1);
    check("restart_done_low", 32'(done[2]), 32'd0);
    check_range("cs_high_min", hi_cnt, 4, 20);
    wait_done(5000);
    step();
    check("restart_wr", 32'(wr_cnt), 32'd4);
    check("restart_sb", 32'(exp_q.size()), 32'd0);
    check_range("restart_busy", busy_cnt, 255, 257);

    check("protocol", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
